// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter sharing one 16-bit barrel shifter, with a registered valid/ready result port.
// Optional build macro: SHIFT_ARB_FIXED_PRIO_EN gives requester 0 absolute priority.

module shifter (
    input  logic [15:0] shift_in,
    input  logic [3:0]  shamt,
    input  logic [1:0]  mode,
    output logic [15:0] shift_out
);
    logic signed [15:0] sra_in;

    always_comb begin
        sra_in    = $signed(shift_in);
        shift_out = 16'h0000;
        case (mode)
            2'b00:   shift_out = shift_in << shamt;
            2'b01:   shift_out = sra_in >>> shamt;
            // The left term vanishes at shamt 0 because a 16-bit value shifted by 16 is zero.
            2'b10:   shift_out = (shift_in >> shamt) | (shift_in << (5'd16 - {1'b0, shamt}));
            default: shift_out = 16'h0000;
        endcase
    end
endmodule

module shift_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_data,
    input  logic [3:0]  req0_shamt,
    input  logic [1:0]  req0_mode,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_data,
    input  logic [3:0]  req1_shamt,
    input  logic [1:0]  req1_mode,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_id
);
    logic        slot_free;
    logic        grant1;
    logic        accept;
    logic [15:0] sh_in;
    logic [3:0]  sh_amt;
    logic [1:0]  sh_mode;
    logic [15:0] sh_out;
    logic        vld_p0;
    logic [15:0] data_p0;
    logic        id_p0;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
    logic        last_grant;
`endif

    always_comb begin
        slot_free = ~vld_p0 | res_ready;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
        grant1 = req1_valid & ~req0_valid;
`else
        // On a tie the requester that did not win last time goes next.
        grant1 = req1_valid & (~req0_valid | ~last_grant);
`endif
        req0_ready = ~rst & slot_free & req0_valid & ~grant1;
        req1_ready = ~rst & slot_free & grant1;
        accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        sh_in      = grant1 ? req1_data  : req0_data;
        sh_amt     = grant1 ? req1_shamt : req0_shamt;
        sh_mode    = grant1 ? req1_mode  : req0_mode;
    end

    shifter u_shifter (
        .shift_in  (sh_in),
        .shamt     (sh_amt),
        .mode      (sh_mode),
        .shift_out (sh_out)
    );

    // Result register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            data_p0 <= 16'h0000;
            id_p0   <= 1'b0;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else if (accept) begin
            vld_p0  <= 1'b1;
            data_p0 <= sh_out;
            id_p0   <= grant1;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
            last_grant <= grant1;
`endif
        end else if (res_ready) begin
            vld_p0 <= 1'b0;
        end
    end

    assign res_valid = vld_p0;
    assign res_data  = data_p0;
    assign res_id    = id_p0;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed plus randomized bench for shift_arbiter, checked against a transaction-level model.
module tb_shift_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_data, req1_data, res_data;
    logic [3:0]  req0_shamt, req1_shamt;
    logic [1:0]  req0_mode, req1_mode;
    logic        res_valid, res_ready, res_id;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: what the result port should show, and who won the last grant.
    logic        m_vld, m_id, m_last;
    logic [15:0] m_data;
    logic        acc0, acc1;
    logic [15:0] saved;

    always #5 clk = ~clk;

    shift_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_shamt(req0_shamt), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_shamt(req1_shamt), .req1_mode(req1_mode),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id)
    );

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] s,
                                              input logic [1:0] m);
        int x;
        case (m)
            2'd0: x = int'(d) * (1 << s);
            2'd1: begin
                x = d[15] ? int'(d) - 65536 : int'(d);
                x = x >>> s;
            end
            2'd2: x = (int'(d) >> s) | (int'(d) << (16 - int'(s)));
            default: x = 0;
        endcase
        return x[15:0];
    endfunction

    // One clock: check readies against the model, take the edge, update model, check outputs.
    task automatic step();
        logic free, w1;
        free = !m_vld || res_ready;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
        w1 = req1_valid && !req0_valid;
`else
        w1 = req1_valid && (!req0_valid || (m_last == 1'b0));
`endif
        acc1 = !rst && free && w1;
        acc0 = !rst && free && req0_valid && !w1;
        #1;
        check("req0_ready", {15'd0, req0_ready}, {15'd0, acc0});
        check("req1_ready", {15'd0, req1_ready}, {15'd0, acc1});
        @(posedge clk);
        #1;
        if (rst) begin
            m_vld = 0; m_data = 16'h0; m_id = 0; m_last = 1;
        end else if (acc0 || acc1) begin
            m_data = acc1 ? ref_shift(req1_data, req1_shamt, req1_mode)
                          : ref_shift(req0_data, req0_shamt, req0_mode);
            m_vld = 1; m_id = acc1; m_last = acc1;
        end else if (res_ready) begin
            m_vld = 0;
        end
        check("res_valid", {15'd0, res_valid}, {15'd0, m_vld});
        check("res_data", res_data, m_data);
        check("res_id", {15'd0, res_id}, {15'd0, m_id});
        @(negedge clk);
    endtask

    initial begin
        rst = 1; res_ready = 0;
        req0_valid = 0; req0_data = 0; req0_shamt = 0; req0_mode = 0;
        req1_valid = 0; req1_data = 0; req1_shamt = 0; req1_mode = 0;
        m_vld = 0; m_data = 0; m_id = 0; m_last = 1;
        @(negedge clk);
        step();
        rst = 0;

        // r0 SLL 0x0001 by 4
        res_ready = 1;
        req0_valid = 1; req0_data = 16'h0001; req0_shamt = 4; req0_mode = 2'b00;
        step();
        req0_valid = 0;
        check("sll_data", res_data, 16'h0010);
        check("sll_id", {15'd0, res_id}, 16'd0);

        // r1 SRA then ROR back to back
        req1_valid = 1; req1_data = 16'h8000; req1_shamt = 3; req1_mode = 2'b01;
        step();
        check("sra_data", res_data, 16'hF000);
        req1_data = 16'h0001; req1_shamt = 1; req1_mode = 2'b10;
        step();
        check("ror_data", res_data, 16'h8000);
        check("ror_valid", {15'd0, res_valid}, 16'd1);
        check("ror_id", {15'd0, res_id}, 16'd1);
        req1_valid = 0;
        step();

        // Contention for 4 cycles; operands held so the loser's contract is honoured.
        req0_valid = 1; req0_data = 16'h1234; req0_shamt = 2; req0_mode = 2'b10;
        req1_valid = 1; req1_data = 16'hA5A5; req1_shamt = 7; req1_mode = 2'b01;
        for (int i = 0; i < 4; i++) begin
            step();
`ifdef SHIFT_ARB_FIXED_PRIO_EN
            check("tie_id", {15'd0, res_id}, 16'd0);
`else
            check("tie_id", {15'd0, res_id}, 16'(i % 2));
`endif
        end
        req0_valid = 0; req1_valid = 0;
        step();

        // Backpressure: fill the slot, then stall 3 cycles with r0 waiting.
        res_ready = 0;
        req0_valid = 1; req0_data = 16'h00F0; req0_shamt = 4; req0_mode = 2'b00;
        step();
        saved = res_data;
        req0_data = 16'hC003; req0_shamt = 1; req0_mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold", res_data, saved);
        end
        res_ready = 1;
        step();
        check("bp_resume", res_data, 16'hE001);
        req0_valid = 0;

        // Reserved mode
        req0_valid = 1; req0_data = 16'hFFFF; req0_shamt = 5; req0_mode = 2'b11;
        step();
        check("mode3_data", res_data, 16'h0000);
        check("mode3_valid", {15'd0, res_valid}, 16'd1);

        // Reset while a result is pending and a request waits.
        res_ready = 0;
        req0_data = 16'h0101; req0_shamt = 3; req0_mode = 2'b00;
        step();
        rst = 1;
        step();
        rst = 0;
        check("rst_valid", {15'd0, res_valid}, 16'd0);
        check("rst_data", res_data, 16'h0000);
        res_ready = 1;
        req1_valid = 1; req1_data = 16'h0003; req1_shamt = 1; req1_mode = 2'b00;
        step();
        check("rst_tie_id", {15'd0, res_id}, 16'd0);
        req0_valid = 0; req1_valid = 0;
        step();

        // Randomized traffic; a requester only changes its operation once accepted or idle.
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_data  = 16'($urandom);
                req0_shamt = 4'($urandom);
                req0_mode  = 2'($urandom);
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_data  = 16'($urandom);
                req1_shamt = 4'($urandom);
                req1_mode  = 2'($urandom);
            end
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares the single 16-bit barrel `Shifter` (modes SLL/SRA/ROR) between two requesters, the execute-stage ALU path and the memory-address path. Each requester uses a valid/ready handshake. Contention is resolved round-robin. Each accepted operation's result is registered and returned through a valid/ready output port, tagged with the winning requester's ID. The block sits in the EX stage between operand forwarding and the EX/MEM pipeline register.

## Interface
Parameters:
- none (width fixed at 16 data bits, 4 shift-amount bits, 2 mode bits)

Ports:
- `clk` input 1: the one clock; all state updates on its rising edge
- `rst` input 1: synchronous, active-high reset
- `req0_valid` input 1: requester 0 (ALU) has an operation
- `req0_ready` output 1: requester 0 operation accepted this cycle when high with `req0_valid`
- `req0_data` input 16: requester 0 shift operand
- `req0_shamt` input 4: requester 0 shift amount, 0-15
- `req0_mode` input 2: requester 0 mode; 00 SLL, 01 SRA, 10 ROR, 11 reserved
- `req1_valid`, `req1_ready`, `req1_data`, `req1_shamt`, `req1_mode`: same as requester 0, for requester 1 (address path)
- `res_valid` output 1: result register holds a valid result
- `res_ready` input 1: consumer takes the result this cycle
- `res_data` output 16: registered shifter result
- `res_id` output 1: requester that issued `res_data` (0 or 1)

## Operation
- The output slot is free when `~res_valid | res_ready`. No request is accepted while the slot is not free.
- Grant, combinational:
  - Only one requester valid: that requester wins.
  - Both valid: the requester not named by `last_grant` wins.
  - The winner's `reqN_ready` equals `slot_free`. The loser's ready is 0.
- Exactly one `Shifter` instance. Its inputs are muxed from the winner's data/shamt/mode. `Shift_Out` is combinational into the result register.
- On acceptance (`reqN_valid & reqN_ready`):
  - `res_data` <= shifter output
  - `res_id` <= N
  - `res_valid` <= 1
  - `last_grant` <= N
- A consume with no acceptance in the same cycle: `res_valid` <= 0. `res_data` and `res_id` hold.
- Consume and acceptance in the same cycle: the register is overwritten and `res_valid` stays 1. This gives full throughput.
- Mode 11 produces result 0x0000. It is accepted like any other request; no error is raised.
- Arithmetic follows the `Shifter` rules:
  - SLL zero-fills.
  - SRA replicates bit 15.
  - ROR rotates right.
  - A shift amount of 0 passes the operand through unchanged.
- Requester contract: while `valid` is high and `ready` is low, the requester holds data/shamt/mode stable. The arbiter may change its grant between cycles only if `last_grant` changed.

## Timing
- Latency: an operation accepted at edge N is visible on `res_*` after edge N, i.e. in cycle N+1.
- Throughput: one operation per cycle while the consumer keeps `res_ready` high.
- Reset values:
  - `res_valid` = 0
  - `res_data` = 0x0000
  - `res_id` = 0
  - `last_grant` = 1, so requester 0 wins the first tie
- `reqN_ready` outputs are combinational and are 0 during reset.
- Reset asserted while a result is pending: the result is discarded and no handshake completes on that edge.
- Backpressure: while `res_valid` = 1 and `res_ready` = 0, all `res_*` outputs hold stable and both `reqN_ready` = 0.
- Fairness: under continuous contention with `res_ready` = 1, grants alternate 0,1,0,1,...

## Configuration
- `SHIFT_ARB_FIXED_PRIO_EN`:
  - Defined: requester 0 always wins contention and `last_grant` is not used. Requester 1 is served only on cycles when `req0_valid` = 0.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset, then r0 sends SLL 0x0001 shamt 4 with `res_ready` = 1 -> cycle 2 shows `res_valid` = 1, `res_data` = 0x0010, `res_id` = 0.
- r1 sends SRA 0x8000 shamt 3, then ROR 0x0001 shamt 1 back-to-back -> results 0xF000 then 0x8000, both `res_id` = 1, no bubble between them.
- Both requesters valid for 4 cycles, `res_ready` = 1 -> `res_id` sequence 0,1,0,1. With `SHIFT_ARB_FIXED_PRIO_EN` the sequence is 0,0,0,0 and `req1_ready` stays 0.
- Result pending with `res_ready` = 0 for 3 cycles while r0 is valid -> `req0_ready` = 0 and `res_data` stable. When `res_ready` rises, the pending result is consumed and the new one is accepted in the same cycle.
- r0 sends mode 11, data 0xFFFF, shamt 5 -> `res_data` = 0x0000, `res_valid` = 1.
- `rst` asserted for 1 cycle while `res_valid` = 1 -> next cycle `res_valid` = 0, `res_data` = 0x0000. The first tie after reset is granted to r0.
